c64_exp_responder: RTL and testbench
====================================

// Module: c64_exp_responder
// PURPOSE
//  C64 expansion-port ROM/IO responder: generalised successor of the fixed XOR EXROM test pattern.
//  Synchronises ROML/H and IO1/2 selects into sysclk, answers ROM reads with a selectable pattern, and serves a
//  register bank in the IO window (writable, so the C64 itself selects mode/pattern).
//  Sits between the C64 bus pins and the chameleon2 top; top only muxes low_d with data_oe.
// PARAMETERS
//  SYNC_STAGES   2    synchroniser depth for romlh/ioef/rw_in (>=2)
//  NUM_REGS      8    IO register count, power of 2, 2..256; index = addr[$clog2(NUM_REGS)-1:0]
//  WR_SETTLE     4    sysclk cycles after write-select before data_in is captured (>=1)
//  HOLD_CYCLES   3    sysclk cycles the data bus stays driven after select drops (>=0)
//  RESET_MODE    8'h80  reset value of reg0 (mode register)
// PORTS
//  clk        in   1   system clock (sysclk, 100 MHz)
//  reset      in   1   synchronous, active-high
//  romlh      in   1   ROML|ROMH select, active-high, async to clk
//  ioef       in   1   IO1|IO2 select, active-high, async to clk
//  rw_in      in   1   C64 R/W (1 = read), async
//  addr       in  16   low_a from C64
//  data_in    in   8   low_d from C64
//  data_out   out  8   value to drive onto low_d
//  data_oe    out  1   1 = drive low_d; also used as sd_oe = ~data_oe
//  exrom_out  out  1   EXROM assert (1 = pull line low), = reg0[7]
//  game_out   out  1   GAME assert, = reg0[6]
//  rom_hits   out 16   ROM read accesses since reset, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: data_out=0, data_oe=0, reg0=RESET_MODE, other regs=0, rom_hits=0, pattern counter=0, state IDLE.
//  Inputs pass SYNC_STAGES flops; addr/data_in sampled in the same cycle the synchronised select is seen.
//  FSM states: IDLE, RD_ROM, RD_IO, WR_WAIT, HOLD.
//   IDLE: sync romlh & rw -> RD_ROM; sync ioef & rw -> RD_IO; sync ioef & ~rw -> WR_WAIT (counter=WR_SETTLE).
//     romlh & ~rw ignored (ROM is read-only). romlh and ioef both high: ioef wins.
//   RD_ROM/RD_IO: data_oe=1 from the cycle after entry; data_out recomputed every cycle from live addr.
//     Select low -> HOLD (HOLD_CYCLES=0: straight to IDLE, data_oe=0 next cycle).
//   HOLD: data_out frozen, data_oe=1 for HOLD_CYCLES cycles, then IDLE with data_oe=0.
//     New select during HOLD: abort hold, take the IDLE transition for that select the same cycle.
//   WR_WAIT: count down; at 0 write data_in to reg[idx], then wait for select low -> IDLE. data_oe=0 throughout.
//     Select drops before count 0: write discarded, -> IDLE.
//  ROM pattern by reg0[1:0]: 0 = addr[15:8]^addr[7:0]; 1 = addr[7:0]; 2 = pattern counter; 3 = reg1.
//   Pattern counter (8 bit) and rom_hits increment once per RD_ROM entry; counter used value is pre-increment.
//  IO read returns reg[idx]; reg0 read returns full byte; idx>=NUM_REGS impossible by construction.
//  reset mid-access: all state to reset values next cycle, data_oe=0 immediately after reset edge.
// STRUCTURE
//  Package c64_exp_pkg: state enum, pattern-mode constants (PAT_XOR, PAT_ADDR, PAT_CNT, PAT_REG), reg0 bit indices.
//  Sub-module: c64_bus_sync (SYNC_STAGES flop chain, 3 bits wide), instantiated once.
// TESTING
//  Reset, romlh read addr=16'h8123, mode 0 -> data_out=8'hA2, data_oe=1 after SYNC_STAGES+1 cycles.
//  IO write 8'h02 to $DE00 held >WR_SETTLE, then 3 ROM reads -> data 00,01,02; rom_hits=3.
//  IO write reg1=8'h5A, reg0=8'h83; ROM read -> 8'h5A; exrom_out=1, game_out=0.
//  Select drops: data_oe stays 1 exactly HOLD_CYCLES cycles; new romlh inside hold -> no gap in data_oe.
//  Write select pulse shorter than WR_SETTLE -> register unchanged; romlh write -> no drive, no reg change.
//  Assert reset during RD_ROM -> data_oe=0 next cycle, reg0=8'h80, rom_hits=0.

Source files
------------

// File: rtl/c64_exp_pkg.sv
// c64_exp_pkg: shared state, pattern-mode and register-bit definitions for the expansion responder
package c64_exp_pkg;
  typedef enum logic [2:0] {IDLE, RD_ROM, RD_IO, WR_WAIT, HOLD} state_t;
  localparam logic [1:0] PAT_XOR = 2'd0;
  localparam logic [1:0] PAT_ADDR = 2'd1;
  localparam logic [1:0] PAT_CNT = 2'd2;
  localparam logic [1:0] PAT_REG = 2'd3;
  localparam int REG0_EXROM = 7;
  localparam int REG0_GAME = 6;
  function automatic logic [7:0] rom_pattern(input logic [1:0] mode, input logic [15:0] a,
                                             input logic [7:0] cnt, input logic [7:0] r1);
    return mode == PAT_XOR ? a[15:8] ^ a[7:0] : mode == PAT_ADDR ? a[7:0] : mode == PAT_CNT ? cnt : r1;
  endfunction
endpackage

// File: rtl/c64_bus_sync.sv
// c64_bus_sync: multi-stage synchroniser bringing the asynchronous bus selects into clk
module c64_bus_sync #(
  parameter int STAGES = 2,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) s[i] <= '0;
    end else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[STAGES-1];
endmodule

// File: rtl/c64_exp_responder.sv
// c64_exp_responder: C64 expansion-port ROM/IO responder with pattern generator and writable IO register bank
module c64_exp_responder
  import c64_exp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS = 8,
  parameter int WR_SETTLE = 4,
  parameter int HOLD_CYCLES = 3,
  parameter logic [7:0] RESET_MODE = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        romlh,
  input  logic        ioef,
  input  logic        rw_in,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        exrom_out,
  output logic        game_out,
  output logic [15:0] rom_hits
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [7:0] SETTLE_C = 8'(WR_SETTLE);
  localparam logic [7:0] HOLD_C = 8'(HOLD_CYCLES);
  logic [2:0] sy;
  logic rom_s, io_s, rd_s, wr_en, hit;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, pat_cnt, dout_n, rom_d;
  logic oe_n;
  logic [7:0] regs [NUM_REGS];
  logic [IW-1:0] idx, widx, widx_n;
  c64_bus_sync #(.STAGES(SYNC_STAGES), .W(3)) u_sync (
    .clk(clk), .reset(reset), .d({romlh, ioef, rw_in}), .q(sy)
  );
  assign {rom_s, io_s, rd_s} = sy;
  assign idx = addr[IW-1:0];
  assign exrom_out = regs[0][REG0_EXROM];
  assign game_out = regs[0][REG0_GAME];
  assign rom_d = rom_pattern(regs[0][1:0], addr, state == RD_ROM ? pat_cnt - 8'd1 : pat_cnt, regs[1]);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dout_n = data_out;
    oe_n = data_oe;
    widx_n = widx;
    wr_en = 1'b0;
    hit = 1'b0;
    case (state)
      RD_ROM, RD_IO: begin
        if (state == RD_ROM ? rom_s : io_s) begin
          dout_n = state == RD_ROM ? rom_d : regs[idx];
        end else begin
          state_n = HOLD_CYCLES == 0 ? IDLE : HOLD;
          cnt_n = HOLD_C;
          oe_n = HOLD_CYCLES != 0;
        end
      end
      WR_WAIT: begin
        if (!io_s) state_n = IDLE;
        else if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
          wr_en = cnt == 8'd1;
        end
      end
      HOLD: begin
        cnt_n = cnt - 8'd1;
        state_n = cnt == 8'd1 ? IDLE : HOLD;
        oe_n = cnt != 8'd1;
      end
      default: ;
    endcase
    if ((state == IDLE || state == HOLD) && (io_s || (rom_s && rd_s))) begin
      if (io_s && rd_s) begin
        state_n = RD_IO;
        oe_n = 1'b1;
        dout_n = regs[idx];
      end else if (io_s) begin
        state_n = WR_WAIT;
        oe_n = 1'b0;
        cnt_n = SETTLE_C;
        widx_n = idx;
      end else begin
        state_n = RD_ROM;
        oe_n = 1'b1;
        dout_n = rom_d;
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pat_cnt <= '0;
      rom_hits <= '0;
      data_out <= '0;
      data_oe <= 1'b0;
      widx <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= i == 0 ? RESET_MODE : 8'h00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      data_out <= dout_n;
      data_oe <= oe_n;
      widx <= widx_n;
      if (hit) begin
        pat_cnt <= pat_cnt + 8'd1;
        rom_hits <= rom_hits + 16'd1;
      end
      if (wr_en) regs[widx] <= data_in;
    end
  end
endmodule

// File: tb/tb_c64_exp_responder.sv
// tb_c64_exp_responder: directed table-driven and sequence checks of the expansion responder
module tb_c64_exp_responder;
  localparam int SYNC = 2;
  localparam int HOLD = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic romlh = 1'b0, ioef = 1'b0, rw_in = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic data_oe, exrom_out, game_out;
  logic [15:0] rom_hits;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [15:0] a;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [5];
  c64_exp_responder #(
    .SYNC_STAGES(SYNC), .NUM_REGS(8), .WR_SETTLE(4), .HOLD_CYCLES(HOLD), .RESET_MODE(8'h80)
  ) dut (
    .clk(clk), .reset(reset), .romlh(romlh), .ioef(ioef), .rw_in(rw_in), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .exrom_out(exrom_out),
    .game_out(game_out), .rom_hits(rom_hits)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    ioef = 1'b1;
    rw_in = 1'b0;
    addr = a;
    data_in = d;
    repeat (12) @(negedge clk);
    ioef = 1'b0;
    rw_in = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic read_cycle(input bit rom, input logic [15:0] a, input logic [7:0] exp, input string nm);
    int n;
    romlh = rom;
    ioef = !rom;
    rw_in = 1'b1;
    addr = a;
    n = 0;
    while (!data_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s latency", nm), n, SYNC + 1);
    if (data_oe) begin
      chk(nm, data_out, exp);
      @(negedge clk);
      chk($sformatf("%s held", nm), data_out, exp);
    end
    romlh = 1'b0;
    ioef = 1'b0;
    n = 0;
    while (data_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s release", nm), data_oe, 1'b0);
    @(negedge clk);
  endtask
  initial begin
    tv[0] = '{16'h8123, 8'h80, 8'h00, 8'hA2};
    tv[1] = '{16'hFF0F, 8'h40, 8'h00, 8'hF0};
    tv[2] = '{16'hA055, 8'h01, 8'h11, 8'h55};
    tv[3] = '{16'h9F3C, 8'h83, 8'h5A, 8'h5A};
    tv[4] = '{16'hE000, 8'hC1, 8'h00, 8'h00};
    do_reset();
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_oe", data_oe, 1'b0);
    chk("reset exrom", exrom_out, 1'b1);
    chk("reset game", game_out, 1'b0);
    chk("reset rom_hits", rom_hits, 16'h0);
    read_cycle(1'b1, 16'h8123, 8'hA2, "first rom read");
    for (int i = 0; i < 5; i++) begin
      io_write(16'hDE01, tv[i].r1);
      io_write(16'hDE00, tv[i].r0);
      read_cycle(1'b1, tv[i].a, tv[i].exp, $sformatf("vec%0d rom", i));
      chk($sformatf("vec%0d exrom", i), exrom_out, tv[i].r0[7]);
      chk($sformatf("vec%0d game", i), game_out, tv[i].r0[6]);
      read_cycle(1'b0, 16'hDE00, tv[i].r0, $sformatf("vec%0d reg0", i));
      read_cycle(1'b0, 16'hDE09, tv[i].r1, $sformatf("vec%0d reg1 alias", i));
    end
    chk("rom_hits after table", rom_hits, 16'd6);
    do_reset();
    io_write(16'hDE00, 8'h02);
    read_cycle(1'b1, 16'h8000, 8'h00, "cnt read0");
    read_cycle(1'b1, 16'h8001, 8'h01, "cnt read1");
    read_cycle(1'b1, 16'hA000, 8'h02, "cnt read2");
    chk("cnt rom_hits", rom_hits, 16'd3);
    do_reset();
    begin
      int n, k, gaps;
      romlh = 1'b1;
      rw_in = 1'b1;
      addr = 16'h8123;
      n = 0;
      while (!data_oe && n < 20) begin
        @(negedge clk);
        n++;
      end
      romlh = 1'b0;
      k = 0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (data_oe) k++;
      end while (data_oe && n < 20);
      chk("hold length", k, SYNC + HOLD);
      repeat (2) @(negedge clk);
      romlh = 1'b1;
      n = 0;
      while (!data_oe && n < 20) begin
        @(negedge clk);
        n++;
      end
      romlh = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      romlh = 1'b1;
      gaps = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (!data_oe) gaps++;
      end
      chk("hold retrigger gaps", gaps, 0);
      chk("hold retrigger hits", rom_hits, 16'd3);
      chk("hold retrigger data", data_out, 8'hA2);
      romlh = 1'b0;
      repeat (12) @(negedge clk);
    end
    io_write(16'hDE01, 8'h33);
    ioef = 1'b1;
    rw_in = 1'b0;
    addr = 16'hDE01;
    data_in = 8'h77;
    repeat (SYNC + 1) @(negedge clk);
    ioef = 1'b0;
    rw_in = 1'b1;
    repeat (6) @(negedge clk);
    read_cycle(1'b0, 16'hDE01, 8'h33, "short write reg1");
    begin
      int drv;
      drv = 0;
      romlh = 1'b1;
      rw_in = 1'b0;
      addr = 16'h8001;
      data_in = 8'h99;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (data_oe) drv++;
      end
      romlh = 1'b0;
      rw_in = 1'b1;
      repeat (4) @(negedge clk);
      chk("rom write drive", drv, 0);
    end
    chk("rom write hits", rom_hits, 16'd3);
    read_cycle(1'b0, 16'hDE01, 8'h33, "rom write reg1");
    read_cycle(1'b0, 16'hDE00, 8'h80, "rom write reg0");
    io_write(16'hDE00, 8'h43);
    begin
      int n;
      romlh = 1'b1;
      rw_in = 1'b1;
      addr = 16'h8000;
      n = 0;
      while (!data_oe && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("mid reset pre oe", data_oe, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid reset oe", data_oe, 1'b0);
      chk("mid reset data", data_out, 8'h00);
      chk("mid reset hits", rom_hits, 16'h0);
      chk("mid reset exrom", exrom_out, 1'b1);
      chk("mid reset game", game_out, 1'b0);
      romlh = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk);
    end
    read_cycle(1'b0, 16'hDE00, 8'h80, "post reset reg0");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
